// File: rtl/ddr_port_ctrl_if.sv
// Stream, address-generator and memory-command signals of one DDR port.
// The slave view belongs to the controller; the master view belongs to its surroundings.
interface ddr_port_ctrl_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [24:0]   wr_addr;
    logic [24:0]   rd_addr;
    logic          read_en;
    logic          wr_addr_up;
    logic          rd_addr_up;
    logic          mem_cmd_valid;
    logic          mem_cmd_we;
    logic [24:0]   mem_cmd_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_cmd_ready;
    logic          mem_rdata_valid;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          err_unexp;

    modport slave (
        input  in_valid, in_data, wr_addr, rd_addr, read_en,
        input  mem_cmd_ready, mem_rdata_valid, mem_rdata, out_ready,
        output in_ready, wr_addr_up, rd_addr_up,
        output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
        output out_valid, out_data, err_unexp
    );

    modport master (
        output in_valid, in_data, wr_addr, rd_addr, read_en,
        output mem_cmd_ready, mem_rdata_valid, mem_rdata, out_ready,
        input  in_ready, wr_addr_up, rd_addr_up,
        input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_wdata,
        input  out_valid, out_data, err_unexp
    );
endinterface

// File: rtl/ddr_port_ctrl.sv
// Single-port DDR command sequencer: buffers a write stream, issues credit-limited reads,
// arbitrates one command at a time and returns read data in order.
module ddr_port_ctrl #(
    parameter int DW       = 32,
    parameter int WF_DEPTH = 4,
    parameter int RF_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    ddr_port_ctrl_if.slave bus
);
    localparam int WPW = (WF_DEPTH > 1) ? $clog2(WF_DEPTH) : 1;
    localparam int WCW = $clog2(WF_DEPTH + 1);
    localparam int RPW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam int RCW = $clog2(RF_DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] UPD   = 2'd2;

    typedef struct packed {
        logic          we;
        logic [24:0]   addr;
        logic [DW-1:0] data;
    } cmd_t;

    function automatic logic [WPW-1:0] wf_nxt(input logic [WPW-1:0] p);
        return (p == WPW'(WF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [RPW-1:0] rf_nxt(input logic [RPW-1:0] p);
        return (p == RPW'(RF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [1:0]                  state;
    cmd_t                        cmd;
    logic                        last_we;
    logic                        err;

    logic [WF_DEPTH-1:0][DW-1:0] wf_mem;
    logic [WPW-1:0]              wf_wp, wf_rp;
    logic [WCW-1:0]              wf_cnt;
    logic                        wf_push, wf_pop, wf_full;

    logic [RF_DEPTH-1:0][DW-1:0] rf_mem;
    logic [RPW-1:0]              rf_wp, rf_rp;
    logic [RCW-1:0]              rf_cnt;
    logic                        rf_push, rf_pop;

    logic [RCW-1:0]              outst;
    logic [RCW:0]                credit_sum;
    logic                        rd_acc, unexp;
    logic                        wr_elig, rd_elig, gnt_we;

    // ---------------- write buffer ----------------
    assign wf_full = (wf_cnt == WCW'(WF_DEPTH));
    assign wf_push = bus.in_valid && !wf_full;
    assign wf_pop  = (state == ISSUE) && bus.mem_cmd_ready && cmd.we;

    always_ff @(posedge clk) begin
        if (wf_push)
            wf_mem[wf_wp] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wf_wp  <= '0;
            wf_rp  <= '0;
            wf_cnt <= '0;
        end else begin
            if (wf_push) wf_wp <= wf_nxt(wf_wp);
            if (wf_pop)  wf_rp <= wf_nxt(wf_rp);
            wf_cnt <= wf_cnt + WCW'(wf_push) - WCW'(wf_pop);
        end
    end

    // ---------------- read-return buffer ----------------
    // Only returns backed by an outstanding read are stored; the credit check keeps room for them.
    assign rd_acc  = (state == ISSUE) && bus.mem_cmd_ready && !cmd.we;
    assign rf_push = bus.mem_rdata_valid && (outst != '0);
    assign unexp   = bus.mem_rdata_valid && (outst == '0);
    assign rf_pop  = (rf_cnt != '0) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rf_push)
            rf_mem[rf_wp] <= bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wp  <= '0;
            rf_rp  <= '0;
            rf_cnt <= '0;
        end else begin
            if (rf_push) rf_wp <= rf_nxt(rf_wp);
            if (rf_pop)  rf_rp <= rf_nxt(rf_rp);
            rf_cnt <= rf_cnt + RCW'(rf_push) - RCW'(rf_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outst <= '0;
            err   <= 1'b0;
        end else begin
            case ({rd_acc, rf_push})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
            if (unexp) err <= 1'b1;
        end
    end

    // ---------------- arbitration ----------------
    assign credit_sum = {1'b0, outst} + {1'b0, rf_cnt};
    assign wr_elig    = (wf_cnt != '0);
    assign rd_elig    = bus.read_en && (credit_sum < (RCW+1)'(RF_DEPTH));

    always_comb begin
        gnt_we = wr_elig;
        if (wf_full)
            gnt_we = 1'b1;
        else if (wr_elig && rd_elig)
            gnt_we = ~last_we;
    end

    // Command registers are loaded once in IDLE and held untouched through ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cmd     <= '0;
            last_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_elig || rd_elig) begin
                        state     <= ISSUE;
                        last_we   <= gnt_we;
                        cmd.we    <= gnt_we;
                        cmd.addr  <= gnt_we ? bus.wr_addr : bus.rd_addr;
                        cmd.data  <= gnt_we ? wf_mem[wf_rp] : '0;
                    end
                end
                ISSUE:   if (bus.mem_cmd_ready) state <= UPD;
                UPD:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.in_ready      = !wf_full;
    assign bus.mem_cmd_valid = (state == ISSUE);
    assign bus.mem_cmd_we    = cmd.we;
    assign bus.mem_cmd_addr  = cmd.addr;
    assign bus.mem_wdata     = cmd.data;
    assign bus.wr_addr_up    = (state == UPD) && cmd.we;
    assign bus.rd_addr_up    = (state == UPD) && !cmd.we;
    assign bus.out_valid     = (rf_cnt != '0);
    assign bus.out_data      = (rf_cnt != '0) ? rf_mem[rf_rp] : '0;
    assign bus.err_unexp     = err;
endmodule

// File: doc/ddr_port_ctrl.md
DDR_PORT_CTRL -- requirements
Module: ddr_port_ctrl

Interface
REQ-001 Parameter: DW, 32, data word width in bits.
REQ-002 Parameter: WF_DEPTH, 4, write-buffer depth in words.
REQ-003 Parameter: RF_DEPTH, 8, read-return buffer depth in words.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset as described in REQ-005 and REQ-006.
REQ-005 Port: clk, input, 1, sole clock; all logic on rising edge.
REQ-006 Port: reset, input, 1, synchronous active-high reset.
REQ-007 Port: in_valid, input, 1, write-stream word valid.
REQ-008 Port: in_data, input, DW, write-stream word.
REQ-009 Port: in_ready, output, 1, write buffer not full.
REQ-010 Port: wr_addr, input, 25, current write address from the address generator.
REQ-011 Port: rd_addr, input, 25, current read address from the address generator.
REQ-012 Port: read_en, input, 1, address generator permits reads.
REQ-013 Port: wr_addr_up, output, 1, one-cycle pulse that advances wr_addr.
REQ-014 Port: rd_addr_up, output, 1, one-cycle pulse that advances rd_addr.
REQ-015 Port: mem_cmd_valid, output, 1, memory command valid.
REQ-016 Port: mem_cmd_we, output, 1, 1 = write, 0 = read.
REQ-017 Port: mem_cmd_addr, output, 25, command address.
REQ-018 Port: mem_wdata, output, DW, write data.
REQ-019 Port: mem_cmd_ready, input, 1, memory accepts command.
REQ-020 Port: mem_rdata_valid, input, 1, read data returning, in order.
REQ-021 Port: mem_rdata, input, DW, read data.
REQ-022 Port: out_valid, output, 1, read-stream word valid.
REQ-023 Port: out_data, output, DW, read-stream word.
REQ-024 Port: out_ready, input, 1, downstream accepts the read-stream word.
REQ-025 Port: err_unexp, output, 1, sticky flag: read data arrived with no read outstanding.

Function
REQ-026 Write buffer SHALL be a FIFO of WF_DEPTH words; push on in_valid&in_ready; in_ready = (count<WF_DEPTH).
REQ-027 Read buffer SHALL be a FIFO of RF_DEPTH words; push on mem_rdata_valid when outstanding>0; out_valid = not empty; out_data = head; pop on out_valid&out_ready.
REQ-028 Outstanding counter (0..RF_DEPTH) SHALL increment on read command accept and decrement on counted mem_rdata_valid; simultaneous increment and decrement leaves it unchanged.
REQ-029 Write is eligible when the write FIFO is non-empty; read is eligible when read_en=1 and outstanding + read-FIFO count < RF_DEPTH.
REQ-030 FSM states SHALL be IDLE, ISSUE, UPD.
REQ-031 IDLE: when no request is eligible, stay in IDLE; otherwise grant, latch we/addr (wr_addr or rd_addr)/wdata (write FIFO head) into command registers, and go to ISSUE.
REQ-032 Arbitration SHALL give the grant to write when the write FIFO is full; otherwise, when both are eligible, grant the opposite of the last grant (reset last grant = read, so write goes first); otherwise grant the sole eligible request.
REQ-033 ISSUE: mem_cmd_valid=1 with command fields held stable; on mem_cmd_ready go to UPD, popping the write FIFO if write.
REQ-034 UPD: wr_addr_up or rd_addr_up =1 for exactly this cycle according to the grant, then go to IDLE.
REQ-035 Peak throughput is therefore one command per 3 cycles, and IDLE always samples an already-advanced address.
REQ-036 A read in ISSUE SHALL complete even if read_en deasserts meanwhile.
REQ-037 Counted mem_rdata_valid is never dropped: credit check guarantees read-FIFO space.
REQ-038 mem_rdata_valid with outstanding=0 SHALL be discarded and set err_unexp until reset.

Reset
REQ-039 On reset: FSM=IDLE, both FIFOs empty, outstanding=0, last grant=read, err_unexp=0.
REQ-040 On reset: all outputs 0 except in_ready=1; reset mid-command abandons the command with no up pulse.

Verification
REQ-041 Single write: in_data=0xA5A5A5A5, wr_addr=0x10, ready tied 1 -> cmd (we=1, addr 0x10, data 0xA5A5A5A5) valid 1 cycle, wr_addr_up pulse next cycle, in_ready stays 1.
REQ-042 Backpressure: mem_cmd_ready=0 for 5 cycles during a read -> cmd held stable 6 cycles, single rd_addr_up, outstanding=1.
REQ-043 Credit: read_en=1, out_ready=0, memory returns after 10 cycles -> exactly 8 reads issued, then none until out_ready pops a word.
REQ-044 Arbitration: 4 words written, read_en=1 -> grants W,R,W,R... except W whenever write FIFO full; in_ready=0 at 4 queued.
REQ-045 Error and reset: mem_rdata_valid with no read outstanding -> err_unexp=1, nothing pushed; reset mid-ISSUE -> mem_cmd_valid=0 and no up pulse next cycle, err_unexp=0.
